// File: rtl/fir_xifu_issue_master.sv
// CPU-side initiator of the X-interface issue channel: issues offload requests, tracks
// outstanding transaction IDs and emits the matching commit.
module fir_xifu_issue_master #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned X_RFR_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [31:0]                            req_instr_i,
  input  logic [X_RFR_WIDTH-1:0]                 req_rs1_i,
  input  logic [X_RFR_WIDTH-1:0]                 req_rs2_i,
  input  logic                                   req_kill_i,
  output logic                                   issue_valid_o,
  input  logic                                   issue_ready_i,
  output logic [31:0]                            issue_instr_o,
  output logic [X_RFR_WIDTH-1:0]                 issue_rs0_o,
  output logic [X_RFR_WIDTH-1:0]                 issue_rs1_o,
  output logic [X_ID_WIDTH-1:0]                  issue_id_o,
  input  logic                                   issue_accept_i,
  input  logic                                   issue_writeback_i,
  input  logic                                   issue_loadstore_i,
  output logic                                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]                  commit_id_o,
  output logic                                   commit_kill_o,
  input  logic                                   result_valid_i,
  input  logic [X_ID_WIDTH-1:0]                  result_id_i,
  output logic                                   resp_valid_o,
  output logic                                   resp_accept_o,
  output logic                                   resp_writeback_o,
  output logic                                   resp_loadstore_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;
  localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

  state_e                 state_q, state_d;
  logic [X_ID_WIDTH-1:0]  next_id_q, next_id_d;
  logic [NumIds-1:0]      busy_q, busy_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [31:0]            instr_q, instr_d;
  logic [X_RFR_WIDTH-1:0] rs0_q, rs0_d, rs1_q, rs1_d;
  logic [X_ID_WIDTH-1:0]  id_q, id_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_accept_q, resp_accept_d;
  logic                   resp_wb_q, resp_wb_d;
  logic                   resp_ls_q, resp_ls_d;

  logic can_issue, alloc, kill, retire, dup;

  always_comb begin
    state_d       = state_q;
    next_id_d     = next_id_q;
    busy_d        = busy_q;
    issue_valid_d = issue_valid_q;
    instr_d       = instr_q;
    rs0_d         = rs0_q;
    rs1_d         = rs1_q;
    id_d          = id_q;
    resp_valid_d  = 1'b0;
    resp_accept_d = 1'b0;
    resp_wb_d     = 1'b0;
    resp_ls_d     = 1'b0;
    req_ready_o    = 1'b0;
    commit_valid_o = 1'b0;
    commit_id_o    = '0;
    commit_kill_o  = 1'b0;
    alloc = 1'b0;
    kill  = 1'b0;

    can_issue = req_valid_i & ~busy_q[next_id_q] & (count_q < MaxCnt);

    unique case (state_q)
      StIdle: begin
        if (can_issue) begin
          req_ready_o   = 1'b1;
          instr_d       = req_instr_i;
          rs0_d         = req_rs1_i;
          rs1_d         = req_rs2_i;
          id_d          = next_id_q;
          issue_valid_d = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (issue_ready_i) begin
          issue_valid_d = 1'b0;
          resp_valid_d  = 1'b1;
          resp_accept_d = issue_accept_i;
          resp_wb_d     = issue_writeback_i;
          resp_ls_d     = issue_loadstore_i;
          if (issue_accept_i) begin
            alloc     = 1'b1;
            next_id_d = next_id_q + 1'b1;
            state_d   = StCommit;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StCommit: begin
        commit_valid_o = 1'b1;
        commit_id_o    = id_q;
        commit_kill_o  = req_kill_i;
        kill           = req_kill_i;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A retire of an ID that is not busy has no effect on either the bitmap or the count.
    retire = result_valid_i & busy_q[result_id_i];
    dup    = retire & kill & (result_id_i == id_q);
    if (retire) busy_d[result_id_i] = 1'b0;
    if (kill)   busy_d[id_q]        = 1'b0;
    if (alloc)  busy_d[id_q]        = 1'b1;
    count_d = count_q + CntW'(alloc) - CntW'(retire) - CntW'(kill) + CntW'(dup);

    // Soft clear wins over everything, including a handshake in this cycle.
    if (clear_i) begin
      state_d        = StIdle;
      next_id_d      = '0;
      busy_d         = '0;
      count_d        = '0;
      issue_valid_d  = 1'b0;
      instr_d        = '0;
      rs0_d          = '0;
      rs1_d          = '0;
      id_d           = '0;
      resp_valid_d   = 1'b0;
      resp_accept_d  = 1'b0;
      resp_wb_d      = 1'b0;
      resp_ls_d      = 1'b0;
      req_ready_o    = 1'b0;
      commit_valid_o = 1'b0;
      commit_id_o    = '0;
      commit_kill_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      next_id_q     <= '0;
      busy_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      instr_q       <= '0;
      rs0_q         <= '0;
      rs1_q         <= '0;
      id_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_accept_q <= 1'b0;
      resp_wb_q     <= 1'b0;
      resp_ls_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_id_q     <= next_id_d;
      busy_q        <= busy_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      instr_q       <= instr_d;
      rs0_q         <= rs0_d;
      rs1_q         <= rs1_d;
      id_q          <= id_d;
      resp_valid_q  <= resp_valid_d;
      resp_accept_q <= resp_accept_d;
      resp_wb_q     <= resp_wb_d;
      resp_ls_q     <= resp_ls_d;
    end
  end

  assign issue_valid_o    = issue_valid_q;
  assign issue_instr_o    = instr_q;
  assign issue_rs0_o      = rs0_q;
  assign issue_rs1_o      = rs1_q;
  assign issue_id_o       = id_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_accept_o    = resp_accept_q;
  assign resp_writeback_o = resp_wb_q;
  assign resp_loadstore_o = resp_ls_q;
  assign outstanding_o    = count_q;

endmodule

// File: tb/tb_fir_xifu_issue_master.sv
// Directed plus randomized bench for fir_xifu_issue_master, checked against an ID-set model.
module tb_fir_xifu_issue_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_instr_i = '0;
  logic [31:0] req_rs1_i = '0;
  logic [31:0] req_rs2_i = '0;
  logic        req_kill_i = 1'b0;
  logic        issue_valid_o;
  logic        issue_ready_i = 1'b0;
  logic [31:0] issue_instr_o;
  logic [31:0] issue_rs0_o;
  logic [31:0] issue_rs1_o;
  logic [3:0]  issue_id_o;
  logic        issue_accept_i = 1'b0;
  logic        issue_writeback_i = 1'b0;
  logic        issue_loadstore_i = 1'b0;
  logic        commit_valid_o;
  logic [3:0]  commit_id_o;
  logic        commit_kill_o;
  logic        result_valid_i = 1'b0;
  logic [3:0]  result_id_i = '0;
  logic        resp_valid_o;
  logic        resp_accept_o;
  logic        resp_writeback_o;
  logic        resp_loadstore_o;
  logic [2:0]  outstanding_o;

  fir_xifu_issue_master #(
    .X_ID_WIDTH(4),
    .X_RFR_WIDTH(32),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_kill_i(req_kill_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o),
    .issue_id_o(issue_id_o), .issue_accept_i(issue_accept_i),
    .issue_writeback_i(issue_writeback_i), .issue_loadstore_i(issue_loadstore_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
    .result_valid_i(result_valid_i), .result_id_i(result_id_i),
    .resp_valid_o(resp_valid_o), .resp_accept_o(resp_accept_o),
    .resp_writeback_o(resp_writeback_o), .resp_loadstore_o(resp_loadstore_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: the set of IDs that are allocated and not yet retired or killed.
  bit [15:0]  busy_m = '0;
  logic [3:0] next_id_m = '0;

  // Optional retires injected during the handshake and commit cycles of xact().
  bit         ret_hs_en = 0;
  logic [3:0] ret_hs_id = '0;
  bit         ret_cm_en = 0;
  logic [3:0] ret_cm_id = '0;

  logic [3:0] ids [4];

  function automatic int count_m();
    return $countones(busy_m);
  endfunction

  function automatic bit can_issue_m();
    return !busy_m[next_id_m] && (count_m() < 4);
  endfunction

  function automatic logic [3:0] pick_busy();
    int s;
    s = $urandom_range(15);
    for (int k = 0; k < 16; k++) begin
      if (busy_m[(s + k) % 16]) return 4'((s + k) % 16);
    end
    return 4'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                      input int stall, input bit acc, input bit wb, input bit ls, input bit kl);
    logic [3:0] id;
    id = next_id_m;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_instr_i = instr; req_rs1_i = rs1; req_rs2_i = rs2;
    result_valid_i = 1'b0;
    #1;
    chk("req_ready_idle", req_ready_o, can_issue_m());
    @(negedge clk_i);
    // A fresh pending request with different data during ISSUE must be neither taken nor seen.
    req_instr_i = $urandom(); req_rs1_i = $urandom(); req_rs2_i = $urandom();
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) @(negedge clk_i);
      issue_ready_i     = (k == stall);
      issue_accept_i    = (k == stall) ? acc : 1'($urandom());
      issue_writeback_i = (k == stall) ? wb : 1'($urandom());
      issue_loadstore_i = (k == stall) ? ls : 1'($urandom());
      result_valid_i    = (k == stall) && ret_hs_en;
      result_id_i       = ret_hs_id;
      #1;
      chk("issue_valid", issue_valid_o, 1'b1);
      chk("issue_instr", issue_instr_o, instr);
      chk("issue_rs0", issue_rs0_o, rs1);
      chk("issue_rs1", issue_rs1_o, rs2);
      chk("issue_id", issue_id_o, id);
      chk("req_ready_busy", req_ready_o, 1'b0);
      chk("resp_valid_quiet", resp_valid_o, 1'b0);
      chk("commit_valid_quiet", commit_valid_o, 1'b0);
    end
    @(posedge clk_i);
    if (ret_hs_en) busy_m[ret_hs_id] = 1'b0;
    if (acc) begin
      busy_m[id] = 1'b1;
      next_id_m  = next_id_m + 4'd1;
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; issue_ready_i = 1'b0; req_kill_i = kl;
    result_valid_i = ret_cm_en; result_id_i = ret_cm_id;
    #1;
    chk("issue_valid_drop", issue_valid_o, 1'b0);
    chk("resp_valid", resp_valid_o, 1'b1);
    chk("resp_accept", resp_accept_o, acc);
    chk("resp_writeback", resp_writeback_o, wb);
    chk("resp_loadstore", resp_loadstore_o, ls);
    chk("commit_valid", commit_valid_o, acc);
    chk("commit_id", commit_id_o, acc ? id : 4'd0);
    chk("commit_kill", commit_kill_o, acc & kl);
    chk("outstanding_alloc", outstanding_o, count_m());
    @(posedge clk_i);
    if (ret_cm_en) busy_m[ret_cm_id] = 1'b0;
    if (acc && kl) busy_m[id] = 1'b0;
    @(negedge clk_i);
    req_kill_i = 1'b0; result_valid_i = 1'b0;
    ret_hs_en = 0; ret_cm_en = 0;
    #1;
    chk("resp_valid_pulse", resp_valid_o, 1'b0);
    chk("resp_accept_zero", resp_accept_o, 1'b0);
    chk("commit_valid_pulse", commit_valid_o, 1'b0);
    chk("outstanding_after", outstanding_o, count_m());
  endtask

  task automatic retire(input logic [3:0] id);
    @(negedge clk_i);
    result_valid_i = 1'b1; result_id_i = id;
    #1;
    chk("req_ready_retire", req_ready_o, req_valid_i && can_issue_m());
    @(posedge clk_i);
    busy_m[id] = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk_i);
    result_valid_i = 1'b0;
    #1;
    chk("outstanding_idle", outstanding_o, count_m());
  endtask

  task automatic stall_req(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      req_valid_i = 1'b1; result_valid_i = 1'b0;
      #1;
      chk("stall_ready", req_ready_o, 1'b0);
      chk("stall_issue_valid", issue_valid_o, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_issue_valid", issue_valid_o, 1'b0);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_commit_valid", commit_valid_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 3'd0);
    chk("rst_issue_id", issue_id_o, 4'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single accept, then retire.
    xact(32'h0000_200B, 32'h100, 32'h0, 0, 1, 1, 0, 0);
    retire(4'd0);
    idle_check();
    // Backpressure for five cycles.
    xact(32'hDEAD_BEEF, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1, 0, 1, 0);
    retire(4'd1);
    idle_check();
    // Reject consumes no ID.
    xact(32'h0000_300B, 32'h7, 32'h8, 1, 0, 0, 0, 0);
    chk("reject_next_id_kept", next_id_m, 4'd2);
    // Kill in commit frees the ID without a retire.
    xact(32'h0000_400B, 32'h9, 32'hA, 0, 1, 1, 0, 1);
    chk("kill_outstanding", outstanding_o, 3'd0);

    // Outstanding limit: four accepts, fifth stalls until the third one retires.
    for (int i = 0; i < 4; i++) begin
      ids[i] = next_id_m;
      xact($urandom(), $urandom(), $urandom(), 0, 1, 0, 0, 0);
    end
    chk("limit_full", outstanding_o, 3'd4);
    stall_req(3);
    retire(ids[2]);
    xact(32'h0000_500B, 32'h1, 32'h2, 0, 1, 0, 0, 0);
    // Retire of an ID that is not busy is ignored.
    retire(ids[2]);
    idle_check();
    // Retire concurrent with allocation, then retire concurrent with a kill.
    retire(ids[0]);
    idle_check();
    ret_hs_en = 1; ret_hs_id = ids[1];
    xact($urandom(), $urandom(), $urandom(), 0, 1, 0, 0, 0);
    ret_cm_en = 1; ret_cm_id = ids[3];
    xact($urandom(), $urandom(), $urandom(), 1, 1, 0, 0, 1);

    // Clear during ISSUE drops the transaction and all state.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_instr_i = 32'h0000_600B;
    #1;
    chk("clr_req_ready", req_ready_o, can_issue_m());
    @(negedge clk_i);
    req_valid_i = 1'b0; issue_ready_i = 1'b0;
    #1;
    chk("clr_issue_valid", issue_valid_o, 1'b1);
    @(negedge clk_i);
    clear_i = 1'b1; issue_ready_i = 1'b1; issue_accept_i = 1'b1;
    #1;
    chk("clr_commit_quiet", commit_valid_o, 1'b0);
    @(negedge clk_i);
    clear_i = 1'b0; issue_ready_i = 1'b0; issue_accept_i = 1'b0;
    busy_m = '0; next_id_m = '0;
    #1;
    chk("clr_issue_valid_drop", issue_valid_o, 1'b0);
    chk("clr_resp_quiet", resp_valid_o, 1'b0);
    chk("clr_outstanding", outstanding_o, 3'd0);
    xact(32'h0000_700B, 32'h3, 32'h4, 0, 1, 0, 0, 0);
    chk("clr_first_id", busy_m[0], 1'b1);

    // ID wrap: keep ID 0 busy while the other fifteen come and go.
    for (int i = 1; i < 16; i++) begin
      xact($urandom(), $urandom(), $urandom(), $urandom_range(1), 1, 1'($urandom()), 0, 0);
      retire(4'(i));
      idle_check();
    end
    chk("wrap_next_id", next_id_m, 4'd0);
    stall_req(3);
    retire(4'd0);
    xact(32'h0000_800B, 32'h5, 32'h6, 0, 1, 0, 0, 0);
    chk("wrap_reuse", busy_m[0], 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      while (!can_issue_m()) begin
        retire(pick_busy());
        idle_check();
      end
      if ($urandom_range(3) == 0) begin
        retire(4'($urandom_range(15)));
        idle_check();
      end
      if (count_m() > 0 && $urandom_range(3) == 0) begin
        ret_hs_en = 1; ret_hs_id = pick_busy();
      end
      if (count_m() > 0 && $urandom_range(3) == 0) begin
        ret_cm_en = 1; ret_cm_id = pick_busy();
      end
      xact($urandom(), $urandom(), $urandom(), $urandom_range(3), $urandom_range(3) != 0,
           1'($urandom()), 1'($urandom()), $urandom_range(3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_xifu_issue_master.md
Name: fir_xifu_issue_master

Overview:
- CPU-side initiator of the X-interface issue channel.
- Takes offload candidates from a core decode stage, drives issue_valid/instr/rs/id toward a coprocessor issue decoder, and captures accept/writeback/loadstore.
- Allocates and tracks outstanding transaction IDs and emits the matching commit transaction.
- Serves as the stimulus/driver counterpart of the coprocessor decode stage in core-less integration and standalone test.

Parameters:
X_ID_WIDTH, 4, width of transaction ID
X_RFR_WIDTH, 32, width of each source operand
MAX_OUTSTANDING, 4, max accepted-but-unretired instructions (1..2**X_ID_WIDTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous soft clear
req_valid_i  in  1  upstream offload request valid
req_ready_o  out  1  upstream request consumed this cycle
req_instr_i  in  32  instruction word
req_rs1_i  in  X_RFR_WIDTH  operand rs1 value
req_rs2_i  in  X_RFR_WIDTH  operand rs2 value
req_kill_i  in  1  upstream kill for the instruction in flight (sampled in COMMIT)
issue_valid_o  out  1  issue request valid
issue_ready_i  in  1  coprocessor ready
issue_instr_o  out  32  issued instruction
issue_rs0_o  out  X_RFR_WIDTH  rs[0]
issue_rs1_o  out  X_RFR_WIDTH  rs[1]
issue_id_o  out  X_ID_WIDTH  transaction ID
issue_accept_i  in  1  response: accepted
issue_writeback_i  in  1  response: will write back
issue_loadstore_i  in  1  response: uses LSU
commit_valid_o  out  1  commit pulse
commit_id_o  out  X_ID_WIDTH  committed ID
commit_kill_o  out  1  commit kill flag
result_valid_i  in  1  coprocessor retires an ID
result_id_i  in  X_ID_WIDTH  retired ID
resp_valid_o  out  1  one-cycle upstream report of issue outcome
resp_accept_o  out  1  registered accept
resp_writeback_o  out  1  registered writeback
resp_loadstore_o  out  1  registered loadstore
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  count of busy IDs

Behaviour:
- State: next_id counter, busy[2**X_ID_WIDTH] bitmap, outstanding counter, FSM {IDLE, ISSUE, COMMIT}.
- Reset/clear:
  - All outputs 0, FSM=IDLE, next_id=0, busy=0, count=0.
  - clear_i has priority over all other events, including a pending handshake; the transaction is dropped without resp/commit.
- IDLE:
  - can_issue = req_valid_i & ~busy[next_id] & (count < MAX_OUTSTANDING), computed on registered state.
  - If can_issue: req_ready_o=1 (combinational, same cycle); capture instr/rs1/rs2 into output regs; issue_id_o<=next_id; go ISSUE.
- ISSUE:
  - issue_valid_o=1 from a register.
  - instr/rs/id are held stable until issue_ready_i=1; valid never drops before handshake.
  - Handshake when issue_valid_o & issue_ready_i. Next cycle: issue_valid_o=0; resp_valid_o=1 with registered accept/writeback/loadstore.
  - accept=1: set busy[id], count+1, next_id+1 (wraps modulo 2**X_ID_WIDTH), go COMMIT.
  - accept=0: no ID consumed, no commit, go IDLE.
- COMMIT, one cycle:
  - commit_valid_o=1, commit_id_o=issued id, commit_kill_o=req_kill_i.
  - If kill: clear busy[id] and count-1 in the same update.
  - Go IDLE.
- Minimum spacing is 3 cycles per accepted instruction and 2 per rejected one; no back-to-back overlap.
- Retire: result_valid_i clears busy[result_id_i] and decrements count.
  - Retire of a non-busy ID is ignored; count is unchanged.
  - Simultaneous retire and allocate (same cycle) adjust count by net 0.
  - Simultaneous retire and kill of different IDs: count-2.
- Wrap-around: if busy[next_id] is still set, IDLE stalls (req_ready_o=0) until it is retired. Issue may proceed the cycle after the retire.
- outstanding_o = popcount-equivalent registered counter. It must equal the number of set busy bits at all times.
- resp_* and commit_* are zero whenever their valid is low.

Test Plan:
- Single accept: req instr=0x0000_200B, rs1=0x100, issue_ready=1, accept=1, writeback=1. Expected: issue_valid 1 cycle with id=0; resp_valid with accept=1, wb=1; commit_valid id=0, kill=0; outstanding_o=1. After result_id=0: outstanding_o=0.
- Backpressure: issue_ready low 5 cycles. Expected: issue_valid held 5+1 cycles; instr/rs/id unchanged; req_ready_o pulsed once only.
- Reject: accept=0. Expected: resp_valid with accept=0; no commit; next accepted request still gets id=0.
- Kill: accept=1, req_kill_i=1 in COMMIT. Expected: commit_kill_o=1; outstanding_o returns to 0 without any result; busy[0] clear.
- Outstanding limit: 4 accepts, no retire. Expected: ids 0..3, 5th request stalls (req_ready_o=0). Retiring id=2 lets it issue as id=4 the next cycle.
- ID wrap and clear: MAX_OUTSTANDING=16, 16 accepts with retires except id 0. Expected: 17th request stalls on busy[0] until result_id=0, then issues with id=0. A mid-ISSUE clear_i drops the transaction; outstanding_o=0 and next id=0.
